pc_ctrl: RTL and testbench

Parametrised program-counter controller for the RISC-V core. It replaces the single-interrupt fixed-vector PC register. The block computes sequential fetch addresses internally and accepts branch/jump redirects. It latches multiple interrupt lines into a pending register, vectors to a per-line handler address, and saves/restores the return address through `mret`. It sits at the head of the fetch path, driving the instruction-memory address.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 31 +++
 rtl/pc_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter controller.
//   pc_state_e : controller state (normal execution or inside an interrupt handler)
//   INSN_BYTES : byte size of one instruction, used for the sequential increment
//   MAX_IRQ    : largest supported interrupt line count
//   vec_addr() : handler vector address of line k (caller truncates to XLEN)
package pc_pkg;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StHandler = 1'b1
    } pc_state_e;

    localparam int unsigned INSN_BYTES = 4;
    localparam int unsigned MAX_IRQ    = 16;

    // Computed at 64 bits so any XLEN up to 64 gets a correctly wrapped result after truncation.
    function automatic logic [63:0] vec_addr(input logic [63:0] base,
                                             input logic [63:0] stride,
                                             input int unsigned k);
        return base + stride * 64'(k);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder for pending interrupt lines.
//   i_req    : request vector (NUM_IRQ bits)
//   o_valid  : at least one request bit is set
//   o_idx    : index of the lowest set request bit (0 when none)
//   o_onehot : one-hot mask of the lowest set request bit (0 when none)
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_IRQ-1:0] o_onehot
);

    assign o_valid = |i_req;

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot = i_req & (~i_req + NUM_IRQ'(1));

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter controller with multi-line vectored interrupts.
//   i_clk         : clock, all state updates on the rising edge
//   i_rst         : synchronous active-low reset
//   i_stall       : hold pc/epc/state this cycle (interrupts still latch)
//   i_redirect    : taken branch/jump this cycle, target on i_redirect_pc
//   i_irq         : interrupt request lines, latched into a sticky pending register
//   i_mret        : return from handler (only honoured while in a handler)
//   o_pc          : current fetch address
//   o_epc         : saved return address
//   o_in_handler  : controller is executing an interrupt handler
//   o_irq_ack     : one-cycle one-hot pulse naming the line just taken
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] INT_BASE     = XLEN'(32'h1C09_0000),
    parameter logic [XLEN-1:0] VEC_STRIDE   = XLEN'(32'h10),
    parameter int unsigned     NUM_IRQ      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [XLEN-1:0]    i_redirect_pc,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_mret,
    output logic [XLEN-1:0]    o_pc,
    output logic [XLEN-1:0]    o_epc,
    output logic               o_in_handler,
    output logic [NUM_IRQ-1:0] o_irq_ack
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    if (NUM_IRQ == 0 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
        $fatal(1, "pc_ctrl: NUM_IRQ must be within 1..16");
    end

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_epc;
    pc_state_e          r_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_ack;

    logic [XLEN-1:0]    w_pc_next;
    logic [XLEN-1:0]    w_epc_next;
    pc_state_e          w_state_next;
    logic [NUM_IRQ-1:0] w_pending_next;
    logic [NUM_IRQ-1:0] w_irq_ack_next;

    logic [XLEN-1:0]    w_seq;
    logic [XLEN-1:0]    w_vec;
    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_IRQ-1:0] w_onehot;
    logic               w_take;
    logic               w_ret;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .i_req    (r_pending),
        .o_valid  (w_valid),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_seq = i_redirect ? i_redirect_pc : r_pc + XLEN'(INSN_BYTES);
    assign w_vec = XLEN'(vec_addr(64'(INT_BASE), 64'(VEC_STRIDE), 32'(w_idx)));

    // Takes are decided on the registered pending set, so a line raised at edge N
    // is taken no earlier than edge N+1.
    assign w_take = (r_state == StRun) && !i_stall && w_valid;
    assign w_ret  = (r_state == StHandler) && i_mret && !i_stall;

    // Clearing the taken line wins over a same-edge request on that line.
    assign w_pending_next = (r_pending | i_irq) & ~(w_take ? w_onehot : '0);

    always_comb begin
        w_pc_next      = r_pc;
        w_epc_next     = r_epc;
        w_state_next   = r_state;
        w_irq_ack_next = '0;
        if (!i_stall) begin
            if (w_take) begin
                w_pc_next      = w_vec;
                w_epc_next     = w_seq;
                w_state_next   = StHandler;
                w_irq_ack_next = w_onehot;
            end else if (w_ret) begin
                w_pc_next    = r_epc;
                w_state_next = StRun;
            end else begin
                w_pc_next = w_seq;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc      <= RESET_VECTOR;
            r_epc     <= '0;
            r_state   <= StRun;
            r_pending <= '0;
            r_irq_ack <= '0;
        end else begin
            r_pc      <= w_pc_next;
            r_epc     <= w_epc_next;
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_irq_ack <= w_irq_ack_next;
        end
    end

    assign o_pc         = r_pc;
    assign o_epc        = r_epc;
    assign o_in_handler = (r_state == StHandler);
    assign o_irq_ack    = r_irq_ack;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl with default parameters.
// A behavioural model predicts the registered outputs for each cycle's stimulus; the
// prediction is queued before the clock edge and compared after it.
module tb_pc_ctrl;

    localparam logic [31:0] INT_BASE   = 32'h1C09_0000;
    localparam logic [31:0] VEC_STRIDE = 32'h10;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [3:0]  i_irq;
    logic        i_mret;
    logic [31:0] o_pc;
    logic [31:0] o_epc;
    logic        o_in_handler;
    logic [3:0]  o_irq_ack;

    pc_ctrl u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_irq         (i_irq),
        .i_mret        (i_mret),
        .o_pc          (o_pc),
        .o_epc         (o_epc),
        .o_in_handler  (o_in_handler),
        .o_irq_ack     (o_irq_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        hand;
        logic [3:0]  ack;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_epc  = 32'h0;
    logic        m_hand = 1'b0;
    logic [3:0]  m_pend = 4'h0;
    logic [3:0]  m_ack  = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict the next registered state from the current inputs.
    task automatic model_step();
        logic [31:0] seq;
        logic [3:0]  npend;
        int          k;
        if (!i_rst) begin
            m_pc   = 32'h0;
            m_epc  = 32'h0;
            m_hand = 1'b0;
            m_pend = 4'h0;
            m_ack  = 4'h0;
        end else begin
            seq   = i_redirect ? i_redirect_pc : m_pc + 32'd4;
            npend = m_pend | i_irq;
            m_ack = 4'h0;
            if (!i_stall) begin
                if (!m_hand && m_pend != 4'h0) begin
                    k = 0;
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) k = i;
                    m_pc     = INT_BASE + VEC_STRIDE * k;
                    m_epc    = seq;
                    m_hand   = 1'b1;
                    m_ack    = 4'h0;
                    m_ack[k] = 1'b1;
                    npend[k] = 1'b0;
                end else if (m_hand && i_mret) begin
                    m_pc   = m_epc;
                    m_hand = 1'b0;
                end else begin
                    m_pc = seq;
                end
            end
            m_pend = npend;
        end
    endtask

    // One clock: predict, queue, clock, compare.
    task automatic tick();
        exp_t e;
        model_step();
        e.pc   = m_pc;
        e.epc  = m_epc;
        e.hand = m_hand;
        e.ack  = m_ack;
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        e = sb_q.pop_front();
        check("pc", o_pc, e.pc);
        check("epc", o_epc, e.epc);
        check("in_handler", 32'(o_in_handler), 32'(e.hand));
        check("irq_ack", 32'(o_irq_ack), 32'(e.ack));
    endtask

    initial begin
        i_rst         = 1'b0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_irq         = 4'h0;
        i_mret        = 1'b0;

        // 1. Reset then free run
        tick();
        tick();
        check("rst_pc", o_pc, 32'h0);
        check("rst_hand", 32'(o_in_handler), 32'h0);
        i_rst = 1'b1;
        tick();
        check("run_pc4", o_pc, 32'h4);
        tick();
        check("run_pc8", o_pc, 32'h8);

        // 2. Redirect at pc=8, then stall 3 cycles
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        check("redir_pc", o_pc, 32'h100);
        i_stall = 1'b1;
        repeat (3) tick();
        check("stall_pc", o_pc, 32'h100);
        i_stall = 1'b0;
        tick();
        check("unstall_pc", o_pc, 32'h104);

        // 3. Single IRQ take and return; pending is visible while pc=0x10
        i_redirect = 1'b1; i_redirect_pc = 32'hC;
        tick();
        i_redirect = 1'b0;
        i_irq = 4'b0100;
        tick();
        i_irq = 4'b0000;
        check("pre_take_pc", o_pc, 32'h10);
        tick();
        check("take_pc", o_pc, 32'h1C09_0020);
        check("take_epc", o_epc, 32'h14);
        check("take_ack", 32'(o_irq_ack), 32'h4);
        tick();
        check("ack_pulse", 32'(o_irq_ack), 32'h0);
        // Redirect inside handler, then mret beats a same-cycle redirect
        i_redirect = 1'b1; i_redirect_pc = 32'h1C09_0200;
        tick();
        check("hand_redir", o_pc, 32'h1C09_0200);
        i_mret = 1'b1; i_redirect_pc = 32'h500;
        tick();
        i_mret = 1'b0; i_redirect = 1'b0;
        check("mret_pc", o_pc, 32'h14);
        check("mret_hand", 32'(o_in_handler), 32'h0);

        // 4. Priority and no nesting
        i_irq = 4'b1010;
        tick();
        i_irq = 4'b0000;
        tick();
        check("prio_pc", o_pc, 32'h1C09_0010);
        check("prio_ack", 32'(o_irq_ack), 32'h2);
        tick();
        check("nonest_hand", 32'(o_in_handler), 32'h1);
        i_mret = 1'b1;
        tick();
        i_mret = 1'b0;
        check("ret_e", o_pc, 32'h1C);
        tick();
        check("l3_pc", o_pc, 32'h1C09_0030);
        check("l3_epc", o_epc, 32'h20);
        i_mret = 1'b1;
        tick();
        i_mret = 1'b0;

        // 5. Stall over the take edge
        i_stall = 1'b1; i_irq = 4'b0001;
        tick();
        i_irq = 4'b0000;
        tick();
        check("stall_noack", 32'(o_irq_ack), 32'h0);
        check("stall_notake", 32'(o_in_handler), 32'h0);
        i_stall = 1'b0;
        tick();
        check("late_take", o_pc, 32'h1C09_0000);
        check("late_epc", o_epc, 32'h24);
        i_mret = 1'b1;
        tick();

        // 6. Edge cases: mret in RUN, wrap, reset in handler
        tick();
        check("mret_run", o_pc, 32'h28);
        i_mret = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        tick();
        check("wrap_pc", o_pc, 32'h0);
        i_irq = 4'b0100;
        tick();
        i_irq = 4'b0000;
        tick();
        check("pre_rst_hand", 32'(o_in_handler), 32'h1);
        i_irq = 4'b1000;
        tick();
        i_irq = 4'b0000;
        i_rst = 1'b0;
        tick();
        check("rst_hand_pc", o_pc, 32'h0);
        check("rst_hand_epc", o_epc, 32'h0);
        i_rst = 1'b1;
        tick();
        tick();
        check("rst_pend_clr", 32'(o_in_handler), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_rst         = ($urandom_range(0, 59) != 0);
            i_stall       = ($urandom_range(0, 3) == 0);
            i_redirect    = ($urandom_range(0, 3) == 0);
            i_redirect_pc = $urandom() & 32'hFFFF_FFFC;
            i_irq         = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : 4'h0;
            i_mret        = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
